// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and helpers for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 22;
  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_BURST_LEN  = 4;

  // Advance a port index by one, wrapping back to port 0 after the last port.
  function automatic int wrapInc(input int idx, input int numPorts);
    return (idx + 1 >= numPorts) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-side requests/responses and memory-side signals.
// The slave modport is the arbiter; the master modport is its environment
// (caches plus external memory).
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_PORTS  = DEF_NUM_PORTS
);

  logic [NUM_PORTS-1:0]            i_Req_Valid;
  logic [NUM_PORTS-1:0]            i_Req_Read_Write_n;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_Req_Address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] i_Req_Data;
  logic [NUM_PORTS-1:0]            o_Rsp_Valid;
  logic [NUM_PORTS-1:0]            o_Rsp_Data_Read;
  logic [NUM_PORTS-1:0]            o_Rsp_Last;
  logic [DATA_WIDTH-1:0]           o_Rsp_Data;
  logic                            o_MEM_Valid;
  logic                            o_MEM_Read_Write_n;
  logic [ADDR_WIDTH-1:0]           o_MEM_Address;
  logic [DATA_WIDTH-1:0]           o_MEM_Data;
  logic                            i_MEM_Valid;
  logic                            i_MEM_Data_Read;
  logic                            i_MEM_Last;
  logic [DATA_WIDTH-1:0]           i_MEM_Data;
  logic [NUM_PORTS-1:0]            o_Grant;
  logic                            o_Burst_Error;

  modport slave (
    input  i_Req_Valid, i_Req_Read_Write_n, i_Req_Address, i_Req_Data,
    input  i_MEM_Valid, i_MEM_Data_Read, i_MEM_Last, i_MEM_Data,
    output o_Rsp_Valid, o_Rsp_Data_Read, o_Rsp_Last, o_Rsp_Data,
    output o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
    output o_Grant, o_Burst_Error
  );

  modport master (
    output i_Req_Valid, i_Req_Read_Write_n, i_Req_Address, i_Req_Data,
    output i_MEM_Valid, i_MEM_Data_Read, i_MEM_Last, i_MEM_Data,
    input  o_Rsp_Valid, o_Rsp_Data_Read, o_Rsp_Last, o_Rsp_Data,
    input  o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
    input  o_Grant, o_Burst_Error
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: finds the first requesting port at or after the
// pointer, wrapping around, and reports it as one-hot and as an index.
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_Req,
  input  logic [PORT_W-1:0]    i_Ptr,
  output logic [NUM_PORTS-1:0] o_Onehot,
  output logic [PORT_W-1:0]    o_Index,
  output logic                 o_Found
);

  int                w_Sum;
  logic [PORT_W-1:0] w_Cand;

  // Scan ports starting at the pointer; the first requester found wins and
  // later candidates are ignored so exactly one bit of the one-hot is set.
  always_comb begin
    o_Onehot = '0;
    o_Index  = '0;
    o_Found  = 1'b0;
    w_Sum    = 0;
    w_Cand   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_Sum = int'(i_Ptr) + k;
      if (w_Sum >= NUM_PORTS) begin
        w_Sum = w_Sum - NUM_PORTS;
      end
      w_Cand = PORT_W'(w_Sum);
      if (!o_Found && i_Req[w_Cand]) begin
        o_Found          = 1'b1;
        o_Onehot[w_Cand] = 1'b1;
        o_Index          = w_Cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between several cache requesters.
// A granted port owns the memory until its last beat (or until it drops its
// request); requests pass straight through and responses reach only the owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int PORT_W     = $clog2(NUM_PORTS)
) (
  input logic               i_Clk,
  input logic               i_Reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  arb_state_t           r_State;
  arb_state_t           w_Next_State;
  logic [PORT_W-1:0]    r_Owner;
  logic [PORT_W-1:0]    r_Ptr;
  logic [BEAT_W-1:0]    r_Beat;
  logic                 r_Burst_Error;

  logic [NUM_PORTS-1:0] w_Pick_Onehot;
  logic [PORT_W-1:0]    w_Pick_Index;
  logic                 w_Pick_Found;
  logic                 w_Busy;
  logic                 w_Owner_Valid;
  logic                 w_Owner_Read;
  logic                 w_Beat;
  logic                 w_Done;
  logic                 w_Abort;
  logic [PORT_W-1:0]    w_Ptr_After_Owner;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_Picker (
    .i_Req    (bus.i_Req_Valid),
    .i_Ptr    (r_Ptr),
    .o_Onehot (w_Pick_Onehot),
    .o_Index  (w_Pick_Index),
    .o_Found  (w_Pick_Found)
  );

  // A beat is a read-data strobe for reads and a write-accept strobe for
  // writes; the burst ends on a beat flagged Last, and an owner that lets go
  // of its request on a quiet cycle abandons the burst.
  always_comb begin
    w_Busy            = (r_State == BUSY);
    w_Owner_Valid     = bus.i_Req_Valid[r_Owner];
    w_Owner_Read      = bus.i_Req_Read_Write_n[r_Owner];
    w_Beat            = w_Busy && (w_Owner_Read ? bus.i_MEM_Valid : bus.i_MEM_Data_Read);
    w_Done            = w_Beat && bus.i_MEM_Last;
    w_Abort           = w_Busy && !w_Owner_Valid && !w_Beat;
    w_Ptr_After_Owner = PORT_W'(wrapInc(int'(r_Owner), NUM_PORTS));
  end

  // State register; reset is asynchronous so outputs drop at once.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_Next_State;
    end
  end

  // Next state: grant from IDLE on any request, leave BUSY on last beat or abort.
  always_comb begin
    w_Next_State = r_State;
    case (r_State)
      IDLE:    if (w_Pick_Found) w_Next_State = BUSY;
      BUSY:    if (w_Done || w_Abort) w_Next_State = IDLE;
      default: w_Next_State = IDLE;
    endcase
  end

  // Owner, round-robin pointer, beat counter and the one-cycle error pulse.
  // The pointer moves past the owner whenever its ownership ends, which is
  // what makes continuous requesters take turns.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Owner       <= '0;
      r_Ptr         <= '0;
      r_Beat        <= '0;
      r_Burst_Error <= 1'b0;
    end else begin
      r_Burst_Error <= 1'b0;
      if (r_State == IDLE) begin
        r_Beat <= '0;
        if (w_Pick_Found) begin
          r_Owner <= w_Pick_Index;
        end
      end else if (w_Done) begin
        r_Ptr         <= w_Ptr_After_Owner;
        r_Beat        <= '0;
        r_Burst_Error <= ((r_Beat + BEAT_W'(1)) != BEAT_W'(BURST_LEN));
      end else if (w_Abort) begin
        r_Ptr  <= w_Ptr_After_Owner;
        r_Beat <= '0;
      end else if (w_Beat) begin
        r_Beat <= r_Beat + BEAT_W'(1);
      end
    end
  end

  // Output muxing: in BUSY the owner's request drives memory and memory
  // responses drive only the owner's response bits; in IDLE everything is
  // quiet, so stray memory beats never reach any cache.
  always_comb begin
    bus.o_Grant            = '0;
    bus.o_MEM_Valid        = 1'b0;
    bus.o_MEM_Read_Write_n = 1'b0;
    bus.o_MEM_Address      = '0;
    bus.o_MEM_Data         = '0;
    bus.o_Rsp_Valid        = '0;
    bus.o_Rsp_Data_Read    = '0;
    bus.o_Rsp_Last         = '0;
    bus.o_Rsp_Data         = '0;
    if (r_State == BUSY) begin
      bus.o_Grant[r_Owner]         = 1'b1;
      bus.o_MEM_Valid              = w_Owner_Valid;
      bus.o_MEM_Read_Write_n       = w_Owner_Read;
      bus.o_MEM_Address            = bus.i_Req_Address[int'(r_Owner)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.o_MEM_Data               = bus.i_Req_Data[int'(r_Owner)*DATA_WIDTH +: DATA_WIDTH];
      bus.o_Rsp_Valid[r_Owner]     = bus.i_MEM_Valid;
      bus.o_Rsp_Data_Read[r_Owner] = bus.i_MEM_Data_Read;
      bus.o_Rsp_Last[r_Owner]      = bus.i_MEM_Last;
      bus.o_Rsp_Data               = bus.i_MEM_Data;
    end
  end

  assign bus.o_Burst_Error = r_Burst_Error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single bursts, round-robin ordering,
// write pass-through, short bursts, aborts and asynchronous reset.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 22;
  localparam int NP = 2;
  localparam int BL = 4;

  logic i_Clk;
  logic i_Reset;
  int   assertCount;
  int   failCount;
  int   seenCount;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_PORTS  (NP),
    .BURST_LEN  (BL)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Drive request and memory-side inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] reqValid, input logic [1:0] reqRw,
                               input logic memValid, input logic memDataRead,
                               input logic memLast, input logic [31:0] memData);
    bus.i_Req_Valid        = reqValid;
    bus.i_Req_Read_Write_n = reqRw;
    bus.i_MEM_Valid        = memValid;
    bus.i_MEM_Data_Read    = memDataRead;
    bus.i_MEM_Last         = memLast;
    bus.i_MEM_Data         = memData;
    #1;
  endtask

  // Drive per-port addresses and write data.
  task automatic setPayload(input logic [21:0] addr0, input logic [21:0] addr1,
                            input logic [31:0] data0, input logic [31:0] data1);
    bus.i_Req_Address = {addr1, addr0};
    bus.i_Req_Data    = {data1, data0};
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold reset for two edges with all inputs quiet.
  task automatic resetDut();
    i_Reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    i_Reset = 1'b0;
  endtask

  // Present memory beats one per cycle to the current owner and check routing.
  task automatic runBeats(input int port, input bit isRead, input int count,
                          input int lastAt, output int seen);
    logic [1:0]  expBit;
    logic [31:0] beatData;
    expBit = (port == 0) ? 2'b01 : 2'b10;
    seen   = 0;
    for (int b = 1; b <= count; b++) begin
      tick();
      beatData = 32'hA000_0000 + b;
      applyStimulus(bus.i_Req_Valid, bus.i_Req_Read_Write_n, isRead, !isRead,
                    (b == lastAt), beatData);
      if (isRead) begin
        checkOutput("rspValid", bus.o_Rsp_Valid, expBit);
        checkOutput("rspData", bus.o_Rsp_Data, beatData);
        checkOutput("rspLast", bus.o_Rsp_Last, (b == lastAt) ? expBit : 2'b00);
      end else begin
        checkOutput("rspValidOnWrite", bus.o_Rsp_Valid, 2'b00);
        checkOutput("rspDataReadOther", bus.o_Rsp_Data_Read & ~expBit, 2'b00);
        if (bus.o_Rsp_Data_Read[port]) seen++;
      end
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    setPayload(22'h000100, 22'h000300, 32'h1111_1111, 32'h2222_2222);
    resetDut();

    $display("[TB] reset state");
    checkOutput("resetGrant", bus.o_Grant, 2'b00);
    checkOutput("resetMemValid", bus.o_MEM_Valid, 1'b0);
    checkOutput("resetRspValid", bus.o_Rsp_Valid, 2'b00);
    checkOutput("resetBurstError", bus.o_Burst_Error, 1'b0);

    $display("[TB] test 1: port0 read alone");
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1GrantBeforeEdge", bus.o_Grant, 2'b00);
    tick();
    checkOutput("t1Grant", bus.o_Grant, 2'b01);
    checkOutput("t1MemValid", bus.o_MEM_Valid, 1'b1);
    checkOutput("t1MemRw", bus.o_MEM_Read_Write_n, 1'b1);
    checkOutput("t1MemAddr", bus.o_MEM_Address, 22'h000100);
    runBeats(0, 1'b1, 4, 4, seenCount);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t1IdleGrant", bus.o_Grant, 2'b00);
    checkOutput("t1NoError", bus.o_Burst_Error, 1'b0);

    $display("[TB] test 2: simultaneous requests from reset");
    setPayload(22'h000200, 22'h000300, 32'h1111_1111, 32'h2222_2222);
    resetDut();
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t2FirstGrant", bus.o_Grant, 2'b01);
    checkOutput("t2FirstAddr", bus.o_MEM_Address, 22'h000200);
    runBeats(0, 1'b1, 4, 4, seenCount);
    tick();
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2Bubble1", bus.o_Grant, 2'b00);
    tick();
    checkOutput("t2SecondGrant", bus.o_Grant, 2'b10);
    checkOutput("t2SecondAddr", bus.o_MEM_Address, 22'h000300);
    runBeats(1, 1'b1, 4, 4, seenCount);
    tick();
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2Bubble2", bus.o_Grant, 2'b00);
    tick();
    checkOutput("t2PtrBackToPort0", bus.o_Grant, 2'b01);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t2DroppedMemValid", bus.o_MEM_Valid, 1'b0);
    tick();
    checkOutput("t2AbortIdle", bus.o_Grant, 2'b00);

    $display("[TB] test 3: port1 write burst");
    setPayload(22'h000400, 22'h15A3C0, 32'h1111_1111, 32'hDEADBEEF);
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t3Grant", bus.o_Grant, 2'b10);
    checkOutput("t3MemAddr", bus.o_MEM_Address, 22'h15A3C0);
    checkOutput("t3MemData", bus.o_MEM_Data, 32'hDEADBEEF);
    checkOutput("t3MemRw", bus.o_MEM_Read_Write_n, 1'b0);
    runBeats(1, 1'b0, 4, 4, seenCount);
    checkOutput("t3DataReadCount", seenCount, 4);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t3IdleGrant", bus.o_Grant, 2'b00);
    checkOutput("t3NoError", bus.o_Burst_Error, 1'b0);

    $display("[TB] test 4: short burst");
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t4Grant", bus.o_Grant, 2'b01);
    runBeats(0, 1'b1, 3, 3, seenCount);
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t4ErrorPulse", bus.o_Burst_Error, 1'b1);
    checkOutput("t4IdleGrant", bus.o_Grant, 2'b00);
    tick();
    checkOutput("t4ErrorCleared", bus.o_Burst_Error, 1'b0);

    $display("[TB] test 5: abort then stray beat");
    applyStimulus(2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("t5Grant", bus.o_Grant, 2'b01);
    runBeats(0, 1'b1, 1, 0, seenCount);
    tick();
    applyStimulus(2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5StillOwner", bus.o_Grant, 2'b01);
    checkOutput("t5OwnerDropped", bus.o_MEM_Valid, 1'b0);
    tick();
    applyStimulus(2'b10, 2'b11, 1'b1, 1'b0, 1'b1, 32'h5555_AAAA);
    checkOutput("t5AbortIdle", bus.o_Grant, 2'b00);
    checkOutput("t5StrayRspValid", bus.o_Rsp_Valid, 2'b00);
    checkOutput("t5StrayRspLast", bus.o_Rsp_Last, 2'b00);
    checkOutput("t5AbortNoError", bus.o_Burst_Error, 1'b0);
    tick();
    applyStimulus(2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t5OtherGranted", bus.o_Grant, 2'b10);
    checkOutput("t5StrayNoError", bus.o_Burst_Error, 1'b0);

    $display("[TB] test 6: async reset during BUSY");
    #2;
    i_Reset = 1'b1;
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("t6ResetGrant", bus.o_Grant, 2'b00);
    checkOutput("t6ResetMemValid", bus.o_MEM_Valid, 1'b0);
    checkOutput("t6ResetMemAddr", bus.o_MEM_Address, 22'h0);
    tick();
    i_Reset = 1'b0;
    tick();
    checkOutput("t6FirstGrantPort0", bus.o_Grant, 2'b01);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
